// File: rtl/pipelined_armv8.sv
// Five-stage ARMv8-subset core (IF/ID/EX/MEM/WB) with EX forwarding, load-use
// stall, B/BL resolved in ID and CBZ resolved at the EX/MEM boundary.

module imem (
  input  logic [5:0]  addr,
  output logic [31:0] rdata
);
  logic [31:0] memory [0:63];
  assign rdata = memory[addr];
endmodule

module if_stage (
  input  logic [5:0]  fetch_addr,
  output logic [31:0] instr
);
  imem instruction_memory (.addr(fetch_addr), .rdata(instr));
endmodule

// X31 reads as zero; a read of the register being written sees the new value.
module regs (
  input  logic        clock,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [63:0] wd,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  input  logic [4:0]  rc,
  output logic [63:0] rda,
  output logic [63:0] rdb,
  output logic [63:0] rdc
);
  logic [63:0] regfile [0:31];
  logic        wr_en;

  assign wr_en = we && (wa != 5'd31);

  always_ff @(posedge clock)
    if (wr_en) regfile[wa] <= wd;

  assign rda = (ra == 5'd31) ? 64'd0 : (wr_en && wa == ra) ? wd : regfile[ra];
  assign rdb = (rb == 5'd31) ? 64'd0 : (wr_en && wa == rb) ? wd : regfile[rb];
  assign rdc = (rc == 5'd31) ? 64'd0 : regfile[rc];
endmodule

module id_stage (
  input  logic        clock,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [63:0] wd,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  input  logic [4:0]  rc,
  output logic [63:0] rda,
  output logic [63:0] rdb,
  output logic [63:0] rdc
);
  regs registers (.clock(clock), .we(we), .wa(wa), .wd(wd), .ra(ra), .rb(rb), .rc(rc),
                  .rda(rda), .rdb(rdb), .rdc(rdc));
endmodule

module pipelined_armv8 (
  input  logic        clock,
  input  logic        reset,
  input  logic [17:0] switches,
  output logic [26:0] leds
);
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR} alu_op_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } if_id_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        is_cbz;
    logic        is_bl;
    alu_op_e     alu_op;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [4:0]  rd;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] imm;
    logic [63:0] target;
    logic [63:0] link;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  rd;
    logic [63:0] result;
    logic [63:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic [4:0]  rd;
    logic [63:0] result;
    logic [63:0] load_data;
  } mem_wb_t;

  logic [63:0] pc_q, pc_d;
  if_id_t      if_id_q, if_id_d;
  id_ex_t      id_ex_q, id_ex_d, id_ex_dec;
  ex_mem_t     ex_mem_q, ex_mem_d;
  mem_wb_t     mem_wb_q, mem_wb_d;

  logic [63:0] PC_out;
  logic [31:0] instruction_IF_ID;
  logic [31:0] fetch_instr;
  logic [63:0] dmem [0:63];

  assign PC_out            = pc_q;
  assign instruction_IF_ID = if_id_q.instr;

  if_stage instruction_fetch (.fetch_addr(pc_q[7:2]), .instr(fetch_instr));

  // ---------------- ID ----------------
  logic [31:0] ins;
  logic d_add, d_sub, d_and, d_orr, d_r, d_addi, d_ldur, d_stur, d_cbz, d_b, d_bl;
  logic use_a, use_b, load_use;
  logic [4:0]  rn_addr, rb_addr;
  logic [63:0] rda, rdb, rdc, br_target, wb_data;

  assign ins    = if_id_q.instr;
  assign d_add  = ins[31:21] == 11'b10001011000;
  assign d_sub  = ins[31:21] == 11'b11001011000;
  assign d_and  = ins[31:21] == 11'b10001010000;
  assign d_orr  = ins[31:21] == 11'b10101010000;
  assign d_r    = d_add | d_sub | d_and | d_orr;
  assign d_addi = ins[31:22] == 10'b1001000100;
  assign d_ldur = ins[31:21] == 11'b11111000010;
  assign d_stur = ins[31:21] == 11'b11111000000;
  assign d_cbz  = ins[31:24] == 8'b10110100;
  assign d_b    = ins[31:26] == 6'b000101;
  assign d_bl   = ins[31:26] == 6'b100101;

  // Second read port carries Rt for STUR/CBZ, Rm otherwise.
  assign rn_addr   = ins[9:5];
  assign rb_addr   = (d_stur | d_cbz) ? ins[4:0] : ins[20:16];
  assign use_a     = d_r | d_addi | d_ldur | d_stur;
  assign use_b     = d_r | d_stur | d_cbz;
  assign br_target = if_id_q.pc + {{36{ins[25]}}, ins[25:0], 2'b00};

  assign load_use = id_ex_q.mem_read && (id_ex_q.rd != 5'd31) &&
                    ((use_a && rn_addr == id_ex_q.rd) || (use_b && rb_addr == id_ex_q.rd));

  id_stage instruction_decode (
    .clock(clock), .we(mem_wb_q.reg_write), .wa(mem_wb_q.rd), .wd(wb_data),
    .ra(rn_addr), .rb(rb_addr), .rc(switches[4:0]),
    .rda(rda), .rdb(rdb), .rdc(rdc));

  always_comb begin
    id_ex_dec           = '0;
    id_ex_dec.reg_write = d_r | d_addi | d_ldur | d_bl;
    id_ex_dec.mem_read  = d_ldur;
    id_ex_dec.mem_write = d_stur;
    id_ex_dec.alu_src   = d_addi | d_ldur | d_stur;
    id_ex_dec.is_cbz    = d_cbz;
    id_ex_dec.is_bl     = d_bl;
    id_ex_dec.alu_op    = d_sub ? ALU_SUB : d_and ? ALU_AND : d_orr ? ALU_ORR : ALU_ADD;
    id_ex_dec.rn        = rn_addr;
    id_ex_dec.rm        = rb_addr;
    id_ex_dec.rd        = d_bl ? 5'd30 : ins[4:0];
    id_ex_dec.a         = rda;
    id_ex_dec.b         = rdb;
    id_ex_dec.imm       = d_addi ? {52'd0, ins[21:10]} : {{55{ins[20]}}, ins[20:12]};
    id_ex_dec.target    = if_id_q.pc + {{43{ins[23]}}, ins[23:5], 2'b00};
    id_ex_dec.link      = if_id_q.pc + 64'd4;
  end

  // ---------------- EX ----------------
  logic [63:0] fwd_a, fwd_b, alu_b, alu_out;
  logic        cbz_taken;

  always_comb begin
    fwd_a = id_ex_q.a;
    if (ex_mem_q.reg_write && ex_mem_q.rd != 5'd31 && ex_mem_q.rd == id_ex_q.rn)
      fwd_a = ex_mem_q.result;
    else if (mem_wb_q.reg_write && mem_wb_q.rd != 5'd31 && mem_wb_q.rd == id_ex_q.rn)
      fwd_a = wb_data;
    fwd_b = id_ex_q.b;
    if (ex_mem_q.reg_write && ex_mem_q.rd != 5'd31 && ex_mem_q.rd == id_ex_q.rm)
      fwd_b = ex_mem_q.result;
    else if (mem_wb_q.reg_write && mem_wb_q.rd != 5'd31 && mem_wb_q.rd == id_ex_q.rm)
      fwd_b = wb_data;
    alu_b = id_ex_q.alu_src ? id_ex_q.imm : fwd_b;
    case (id_ex_q.alu_op)
      ALU_SUB: alu_out = fwd_a - alu_b;
      ALU_AND: alu_out = fwd_a & alu_b;
      ALU_ORR: alu_out = fwd_a | alu_b;
      default: alu_out = fwd_a + alu_b;
    endcase
  end

  assign cbz_taken = id_ex_q.is_cbz && (fwd_b == 64'd0);

  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.reg_write  = id_ex_q.reg_write;
    ex_mem_d.mem_read   = id_ex_q.mem_read;
    ex_mem_d.mem_write  = id_ex_q.mem_write;
    ex_mem_d.rd         = id_ex_q.rd;
    ex_mem_d.result     = id_ex_q.is_bl ? id_ex_q.link : alu_out;
    ex_mem_d.store_data = fwd_b;
  end

  // ---------------- MEM / WB ----------------
  always_ff @(posedge clock)
    if (ex_mem_q.mem_write) dmem[ex_mem_q.result[8:3]] <= ex_mem_q.store_data;

  always_comb begin
    mem_wb_d           = '0;
    mem_wb_d.reg_write = ex_mem_q.reg_write;
    mem_wb_d.mem_read  = ex_mem_q.mem_read;
    mem_wb_d.rd        = ex_mem_q.rd;
    mem_wb_d.result    = ex_mem_q.result;
    mem_wb_d.load_data = dmem[ex_mem_q.result[8:3]];
  end

  assign wb_data = mem_wb_q.mem_read ? mem_wb_q.load_data : mem_wb_q.result;

  // Flush beats stall, stall beats an ID branch (which then resolves a cycle later).
  logic [63:0] pc_next;
  always_comb begin
    pc_next        = pc_q + 64'd4;
    if_id_d.instr  = fetch_instr;
    if_id_d.pc     = pc_q;
    id_ex_d        = id_ex_dec;
    if (cbz_taken) begin
      pc_next = id_ex_q.target;
      if_id_d = '0;
      id_ex_d = '0;
    end else if (load_use) begin
      pc_next = pc_q;
      if_id_d = if_id_q;
      id_ex_d = '0;
    end else if (d_b | d_bl) begin
      pc_next = br_target;
      if_id_d = '0;
    end
    pc_d = {56'd0, pc_next[7:0]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  logic leds_unused;
  assign leds_unused = ^{switches[16:5], rdc[63:27]};
  assign leds        = switches[17] ? pc_q[26:0] : rdc[26:0];
endmodule

// File: tb/tb_pipelined_armv8.sv
// Directed bench: reset/fetch, B, BL, forwarding, load-use stall, CBZ and LED mux.
module tb_pipelined_armv8;
  logic        clock = 1'b0;
  logic        reset;
  logic [17:0] switches;
  logic [26:0] leds;
  int checks = 0;
  int errors = 0;

  pipelined_armv8 dut (.clock(clock), .reset(reset), .switches(switches), .leds(leds));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rd, rn, rm);
    return {op, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] enc_addi(input logic [4:0] rd, rn, input logic [11:0] imm);
    return {10'b1001000100, imm, rn, rd};
  endfunction
  function automatic logic [31:0] enc_mem(input logic [10:0] op, input logic [4:0] rt, rn,
                                          input logic [8:0] imm);
    return {op, imm, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_cbz(input logic [4:0] rt, input logic [18:0] imm);
    return {8'b10110100, imm, rt};
  endfunction
  function automatic logic [31:0] enc_b(input logic [5:0] op, input logic [25:0] imm);
    return {op, imm};
  endfunction

  localparam logic [10:0] OP_ADD = 11'b10001011000, OP_SUB = 11'b11001011000,
                          OP_AND = 11'b10001010000, OP_ORR = 11'b10101010000,
                          OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000;
  localparam logic [5:0]  OP_B = 6'b000101, OP_BL = 6'b100101;

  logic [31:0] prog [0:25];
  logic [63:0] exp_pc [1:20];

  initial begin
    switches = 18'h20000;
    reset    = 1'b1;
    #1 reset = 1'b0;
    for (int i = 0; i < 64; i++) dut.instruction_fetch.instruction_memory.memory[i] = 32'd0;
    dut.instruction_fetch.instruction_memory.memory[1] = 32'hDEAD0001;
    dut.instruction_fetch.instruction_memory.memory[2] = 32'hDEAD0002;
    dut.instruction_fetch.instruction_memory.memory[3] = 32'hDEAD0003;
    #15;
    // ---- phase 1: reset state and straight-line fetch ----
    check("rst_pc", dut.PC_out, 64'd0);
    check("rst_ifid", {32'd0, dut.instruction_IF_ID}, 64'd0);
    check("rst_leds_pc", {37'd0, leds}, 64'd0);
    reset = 1'b1;
    check("pre_edge_pc", dut.PC_out, 64'd0);
    tick(); check("f1_pc", dut.PC_out, 64'd4);  check("f1_ifid", {32'd0, dut.instruction_IF_ID}, 64'd0);
    tick(); check("f2_pc", dut.PC_out, 64'd8);  check("f2_ifid", {32'd0, dut.instruction_IF_ID}, 64'hDEAD0001);
    tick(); check("f3_pc", dut.PC_out, 64'd12); check("f3_ifid", {32'd0, dut.instruction_IF_ID}, 64'hDEAD0002);
    tick(); check("f4_ifid", {32'd0, dut.instruction_IF_ID}, 64'hDEAD0003);
    reset = 1'b0;
    #1;
    check("abort_pc", dut.PC_out, 64'd0);
    check("abort_ifid", {32'd0, dut.instruction_IF_ID}, 64'd0);

    // ---- phase 2: program ----
    prog[0]  = enc_addi(5'd16, 5'd31, 12'd20);
    prog[1]  = enc_addi(5'd18, 5'd31, 12'd6);
    prog[2]  = enc_addi(5'd6,  5'd31, 12'd7);
    prog[3]  = enc_b(OP_B, 26'd3);                       // -> word 6
    prog[4]  = enc_addi(5'd16, 5'd31, 12'd99);           // skipped
    prog[5]  = enc_addi(5'd18, 5'd31, 12'd98);           // skipped
    prog[6]  = 32'h8B120202;                             // ADD X2,X16,X18
    prog[7]  = 32'h94000003;                             // BL #3 -> word 10
    prog[8]  = enc_addi(5'd16, 5'd31, 12'd1);            // skipped
    prog[9]  = enc_addi(5'd18, 5'd31, 12'd2);            // skipped
    prog[10] = enc_addi(5'd1, 5'd31, 12'd5);
    prog[11] = enc_r(OP_ADD, 5'd3, 5'd1, 5'd1);
    prog[12] = enc_r(OP_ADD, 5'd8, 5'd1, 5'd3);
    prog[13] = enc_mem(OP_STUR, 5'd16, 5'd31, 9'd8);
    prog[14] = enc_mem(OP_LDUR, 5'd4, 5'd31, 9'd8);
    prog[15] = enc_r(OP_ADD, 5'd5, 5'd4, 5'd18);
    prog[16] = enc_cbz(5'd31, 19'd3);                    // taken -> word 19
    prog[17] = enc_addi(5'd6, 5'd31, 12'd1);             // skipped
    prog[18] = enc_addi(5'd6, 5'd31, 12'd2);             // skipped
    prog[19] = enc_cbz(5'd16, 19'd2);                    // not taken
    prog[20] = enc_addi(5'd9, 5'd31, 12'd3);
    prog[21] = enc_r(OP_SUB, 5'd10, 5'd16, 5'd18);
    prog[22] = enc_r(OP_AND, 5'd11, 5'd16, 5'd18);
    prog[23] = enc_r(OP_ORR, 5'd12, 5'd16, 5'd18);
    prog[24] = enc_r(OP_SUB, 5'd13, 5'd18, 5'd16);
    prog[25] = enc_b(OP_B, 26'd0);                       // park
    for (int i = 0; i < 64; i++) dut.instruction_fetch.instruction_memory.memory[i] = 32'd0;
    for (int i = 0; i < 26; i++) dut.instruction_fetch.instruction_memory.memory[i] = prog[i];

    exp_pc = '{64'd4, 64'd8, 64'd12, 64'd16, 64'd24, 64'd28, 64'd32, 64'd40, 64'd44, 64'd48,
               64'd52, 64'd56, 64'd60, 64'd64, 64'd64, 64'd68, 64'd72, 64'd76, 64'd80, 64'd84};

    @(negedge clock);
    reset = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check($sformatf("pc_e%0d", e), dut.PC_out, exp_pc[e]);
      check($sformatf("leds_pc_e%0d", e), {37'd0, leds}, exp_pc[e]);
      if (e == 5)  check("b_bubble", {32'd0, dut.instruction_IF_ID}, 64'd0);
      if (e == 8)  check("bl_bubble", {32'd0, dut.instruction_IF_ID}, 64'd0);
      if (e == 15) check("stall_hold", {32'd0, dut.instruction_IF_ID}, {32'd0, prog[15]});
      if (e == 18) check("cbz_flush", {32'd0, dut.instruction_IF_ID}, 64'd0);
    end
    for (int e = 0; e < 30; e++) tick();

    check("x16", dut.instruction_decode.registers.regfile[16], 64'd20);
    check("x18", dut.instruction_decode.registers.regfile[18], 64'd6);
    check("x2_b", dut.instruction_decode.registers.regfile[2], 64'd26);
    check("x30_bl", dut.instruction_decode.registers.regfile[30], 64'd32);
    check("x1", dut.instruction_decode.registers.regfile[1], 64'd5);
    check("x3_fwd", dut.instruction_decode.registers.regfile[3], 64'd10);
    check("x8_fwd2", dut.instruction_decode.registers.regfile[8], 64'd15);
    check("dmem1", dut.dmem[1], 64'd20);
    check("x4_ldur", dut.instruction_decode.registers.regfile[4], 64'd20);
    check("x5_ldu", dut.instruction_decode.registers.regfile[5], 64'd26);
    check("x6_cbz", dut.instruction_decode.registers.regfile[6], 64'd7);
    check("x9_nt", dut.instruction_decode.registers.regfile[9], 64'd3);
    check("x10_sub", dut.instruction_decode.registers.regfile[10], 64'd14);
    check("x11_and", dut.instruction_decode.registers.regfile[11], 64'd4);
    check("x12_orr", dut.instruction_decode.registers.regfile[12], 64'd22);
    check("x13_wrap", dut.instruction_decode.registers.regfile[13], 64'hFFFF_FFFF_FFFF_FFF2);

    switches = 18'h00010; #1;
    check("leds_x16", {37'd0, leds}, 64'd20);
    switches = 18'h0000D; #1;
    check("leds_x13", {37'd0, leds}, 64'h7FFFFF2);
    switches = 18'h0001F; #1;
    check("leds_xzr", {37'd0, leds}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
